alu_share_ctrl: RTL and testbench

Shares one ALU instance between two requesters (port 0 and port 1), using valid/ready handshakes and round-robin arbitration.
- Captures the granted operands and function code, then drives the ALU inputs from registers.
- Waits a fixed ALU latency, samples the product and overflow, and returns them to the granted requester as a one-cycle response pulse.
- Sits between requester logic (switch/FSM front-ends) and the ALU in the top level.

---
 rtl/alu_share_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_alu_share_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl
//   Shares one ALU between two valid/ready requesters with round-robin
//   arbitration. Operands are registered onto the ALU inputs at accept,
//   the result is sampled ALU_LAT cycles later and returned to the owner
//   as a one-cycle response pulse.
//
//   Optional build macro: ALU_SHARE_STATS_EN
//     adds saturating 16-bit counters grant_cnt0, grant_cnt1, ovf_cnt.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | no operation in flight; combinational grant, readies live
//   EXEC  | operands on ALU inputs, lat counter runs to ALU_LAT-1
//   DONE  | one cycle; response pulse to the owner, back to IDLE next
module alu_share_ctrl #(
  parameter int WIDTH   = 6,
  parameter int ALU_LAT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic [WIDTH-1:0]   req0_b,
  input  logic [1:0]         req0_func,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic [WIDTH-1:0]   req1_b,
  input  logic [1:0]         req1_func,
  output logic               resp0_valid,
  output logic               resp1_valid,
  output logic [2*WIDTH-1:0] resp_out,
  output logic               resp_err,
  output logic               busy,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [1:0]         alu_func,
  input  logic [2*WIDTH-1:0] alu_out,
  input  logic               alu_ovf
`ifdef ALU_SHARE_STATS_EN
  ,
  output logic [15:0]        grant_cnt0,
  output logic [15:0]        grant_cnt1,
  output logic [15:0]        ovf_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // ALU_LAT is at most 15, so a 4-bit counter covers the whole range.
  localparam int               CNT_W    = 4;
  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(ALU_LAT - 1);

  state_t             state_q, state_d;
  logic               rr_ptr_q, rr_ptr_d;
  logic               owner_q, owner_d;
  logic [CNT_W-1:0]   lat_cnt_q, lat_cnt_d;
  logic [WIDTH-1:0]   alu_a_q, alu_a_d;
  logic [WIDTH-1:0]   alu_b_q, alu_b_d;
  logic [1:0]         alu_func_q, alu_func_d;
  logic [2*WIDTH-1:0] resp_out_q, resp_out_d;
  logic               resp_err_q, resp_err_d;
  logic               resp0_valid_q, resp0_valid_d;
  logic               resp1_valid_q, resp1_valid_d;
  logic               busy_q, busy_d;

  logic               grant_port;
  logic               accept;
  logic               capture;

`ifdef ALU_SHARE_STATS_EN
  logic [15:0]        grant_cnt0_q, grant_cnt0_d;
  logic [15:0]        grant_cnt1_q, grant_cnt1_d;
  logic [15:0]        ovf_cnt_q, ovf_cnt_d;
`endif

  // Arbitration: a lone requester wins, a tie goes to the port rr_ptr names.
  always_comb begin
    if (req0_valid && req1_valid) begin
      grant_port = rr_ptr_q;
    end else begin
      grant_port = req1_valid;
    end
    req0_ready = (state_q == S_IDLE) && req0_valid && !grant_port;
    req1_ready = (state_q == S_IDLE) && req1_valid && grant_port;
    accept     = req0_ready || req1_ready;
    capture    = (state_q == S_EXEC) && (lat_cnt_q == LAT_LAST);
  end

  // Next-state and next-output computation for the sequencer.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    owner_d       = owner_q;
    lat_cnt_d     = lat_cnt_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_func_d    = alu_func_q;
    resp_out_d    = resp_out_q;
    resp_err_d    = resp_err_q;
    resp0_valid_d = 1'b0;
    resp1_valid_d = 1'b0;
    busy_d        = busy_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          alu_a_d    = grant_port ? req1_a    : req0_a;
          alu_b_d    = grant_port ? req1_b    : req0_b;
          alu_func_d = grant_port ? req1_func : req0_func;
          owner_d    = grant_port;
          rr_ptr_d   = !grant_port;
          lat_cnt_d  = '0;
          state_d    = S_EXEC;
          busy_d     = 1'b1;
        end
      end
      S_EXEC: begin
        lat_cnt_d = lat_cnt_q + 1'b1;
        if (capture) begin
          resp_out_d    = alu_out;
          resp_err_d    = alu_ovf;
          resp0_valid_d = !owner_q;
          resp1_valid_d = owner_q;
          state_d       = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

`ifdef ALU_SHARE_STATS_EN
  // Saturating activity counters.
  always_comb begin
    grant_cnt0_d = grant_cnt0_q;
    grant_cnt1_d = grant_cnt1_q;
    ovf_cnt_d    = ovf_cnt_q;
    if (req0_ready && grant_cnt0_q != 16'hFFFF) begin
      grant_cnt0_d = grant_cnt0_q + 16'd1;
    end
    if (req1_ready && grant_cnt1_q != 16'hFFFF) begin
      grant_cnt1_d = grant_cnt1_q + 16'd1;
    end
    if (capture && alu_ovf && ovf_cnt_q != 16'hFFFF) begin
      ovf_cnt_d = ovf_cnt_q + 16'd1;
    end
  end
`endif

  // State and registered outputs; reset drops any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      rr_ptr_q      <= 1'b0;
      owner_q       <= 1'b0;
      lat_cnt_q     <= '0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_func_q    <= '0;
      resp_out_q    <= '0;
      resp_err_q    <= 1'b0;
      resp0_valid_q <= 1'b0;
      resp1_valid_q <= 1'b0;
      busy_q        <= 1'b0;
`ifdef ALU_SHARE_STATS_EN
      grant_cnt0_q  <= '0;
      grant_cnt1_q  <= '0;
      ovf_cnt_q     <= '0;
`endif
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      owner_q       <= owner_d;
      lat_cnt_q     <= lat_cnt_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_func_q    <= alu_func_d;
      resp_out_q    <= resp_out_d;
      resp_err_q    <= resp_err_d;
      resp0_valid_q <= resp0_valid_d;
      resp1_valid_q <= resp1_valid_d;
      busy_q        <= busy_d;
`ifdef ALU_SHARE_STATS_EN
      grant_cnt0_q  <= grant_cnt0_d;
      grant_cnt1_q  <= grant_cnt1_d;
      ovf_cnt_q     <= ovf_cnt_d;
`endif
    end
  end

  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_func    = alu_func_q;
  assign resp_out    = resp_out_q;
  assign resp_err    = resp_err_q;
  assign resp0_valid = resp0_valid_q;
  assign resp1_valid = resp1_valid_q;
  assign busy        = busy_q;

`ifdef ALU_SHARE_STATS_EN
  assign grant_cnt0  = grant_cnt0_q;
  assign grant_cnt1  = grant_cnt1_q;
  assign ovf_cnt     = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: directed vector table plus reset-in-flight and
// withdrawn-request sequences. Inputs change 2 time units after a rising
// edge; outputs are sampled on the falling edge.
module tb_alu_share_ctrl;

  localparam int WIDTH   = 6;
  localparam int ALU_LAT = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic               req0_valid, req0_ready;
  logic [WIDTH-1:0]   req0_a, req0_b;
  logic [1:0]         req0_func;
  logic               req1_valid, req1_ready;
  logic [WIDTH-1:0]   req1_a, req1_b;
  logic [1:0]         req1_func;
  logic               resp0_valid, resp1_valid;
  logic [2*WIDTH-1:0] resp_out;
  logic               resp_err;
  logic               busy;
  logic [WIDTH-1:0]   alu_a, alu_b;
  logic [1:0]         alu_func;
  logic [2*WIDTH-1:0] alu_out = '0;
  logic               alu_ovf = 1'b0;
`ifdef ALU_SHARE_STATS_EN
  logic [15:0]        grant_cnt0, grant_cnt1, ovf_cnt;
`endif

  alu_share_ctrl #(.WIDTH(WIDTH), .ALU_LAT(ALU_LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_func  (req0_func),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_func  (req1_func),
    .resp0_valid(resp0_valid),
    .resp1_valid(resp1_valid),
    .resp_out   (resp_out),
    .resp_err   (resp_err),
    .busy       (busy),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_func   (alu_func),
    .alu_out    (alu_out),
    .alu_ovf    (alu_ovf)
`ifdef ALU_SHARE_STATS_EN
    ,
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1),
    .ovf_cnt    (ovf_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ALU model: 00 add, 01 multiply; overflow when the result needs more
  // than WIDTH bits. One register stage makes the result valid in the
  // second cycle after the operands change, i.e. a latency of 2.
  logic [2*WIDTH-1:0] alu_res;
  logic               alu_res_ovf;
  always_comb begin
    alu_res     = '0;
    alu_res_ovf = 1'b0;
    case (alu_func)
      2'b00: alu_res = {{WIDTH{1'b0}}, alu_a} + {{WIDTH{1'b0}}, alu_b};
      2'b01: alu_res = {{WIDTH{1'b0}}, alu_a} * {{WIDTH{1'b0}}, alu_b};
      default: alu_res = '0;
    endcase
    alu_res_ovf = |alu_res[2*WIDTH-1:WIDTH];
  end
  always @(posedge clk) begin
    alu_out <= alu_res;
    alu_ovf <= alu_res_ovf;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    bit         v0;
    logic [5:0] a0, b0;
    logic [1:0] f0;
    bit         v1;
    logic [5:0] a1, b1;
    logic [1:0] f1;
    bit         hold;      // keep both valids up after the accept
    int         exp_port;
    int         exp_out;
    bit         exp_err;
  } vec_t;

  vec_t vecs[8];

  task automatic drive(input vec_t v);
    req0_valid = v.v0; req0_a = v.a0; req0_b = v.b0; req0_func = v.f0;
    req1_valid = v.v1; req1_a = v.a1; req1_b = v.b1; req1_func = v.f1;
  endtask

  task automatic drop_valids();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  // Returns at the falling edge of the cycle holding a handshake; the
  // accept edge is the next rising edge.
  task automatic wait_accept(output int port, output int edge_n, output bit ok);
    ok = 1'b0; port = -1; edge_n = 0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      chk("one_ready", int'(req0_ready) + int'(req1_ready) <= 1, 1);
      if (req0_valid && req0_ready) begin port = 0; edge_n = cyc + 1; ok = 1'b1; end
      else if (req1_valid && req1_ready) begin port = 1; edge_n = cyc + 1; ok = 1'b1; end
    end
  endtask

  // Called 2 units after the accept edge.
  task automatic wait_resp(input int acc_edge, input int exp_port, input int exp_out,
                           input bit exp_err, input int ea, input int eb, input int ef,
                           input bit post);
    bit         seen = 1'b0;
    bit         bad_ready = 1'b0;
    logic [1:0] pv = '0;
    int         rcyc = 0;
    logic [11:0] rout = '0;
    logic       rerr = 1'b0;
    for (int k = 0; k < 12 && !seen; k++) begin
      @(negedge clk);
      if (k == 0) begin
        chk("alu_a_latched", alu_a, ea);
        chk("alu_b_latched", alu_b, eb);
        chk("alu_func_latched", alu_func, ef);
        chk("busy_exec", busy, 1);
      end
      if (req0_ready || req1_ready) bad_ready = 1'b1;
      if (resp0_valid || resp1_valid) begin
        seen = 1'b1; pv = {resp1_valid, resp0_valid};
        rcyc = cyc; rout = resp_out; rerr = resp_err;
      end
    end
    chk("resp_seen", seen, 1);
    if (seen) begin
      chk("resp_port", pv, (exp_port == 1) ? 2 : 1);
      chk("resp_latency", rcyc - acc_edge, ALU_LAT);
      chk("resp_out", rout, exp_out);
      chk("resp_err", rerr, exp_err);
    end
    chk("no_ready_while_busy", bad_ready, 0);
    if (post) begin
      @(negedge clk);
      chk("pulse_one_cycle", {resp1_valid, resp0_valid}, 0);
      chk("resp_out_hold", resp_out, rout);
      chk("busy_idle", busy, 0);
    end
  endtask

  int  port, edge_n, prev_edge;
  bit  ok;
  int  ea, eb, ef;
  int  r0_cnt, r1_cnt, rdy0_cnt;
  logic [11:0] r1_out;
`ifdef ALU_SHARE_STATS_EN
  logic [15:0] gc0_before;
`endif

  initial begin
    //         v0 a0  b0  f0     v1 a1  b1  f1     hold port out   err
    vecs[0] = '{1, 5,  3,  2'b00, 0, 0,  0,  2'b00, 0,   0,   8,    0};
    vecs[1] = '{0, 0,  0,  2'b00, 1, 63, 63, 2'b01, 0,   1,   3969, 1};
    vecs[2] = '{1, 10, 20, 2'b01, 0, 0,  0,  2'b00, 0,   0,   200,  1};
    vecs[3] = '{0, 0,  0,  2'b00, 1, 7,  9,  2'b00, 0,   1,   16,   0};
    vecs[4] = '{1, 2,  3,  2'b01, 1, 40, 30, 2'b00, 1,   0,   6,    0};
    vecs[5] = '{1, 2,  3,  2'b01, 1, 40, 30, 2'b00, 1,   1,   70,   1};
    vecs[6] = '{1, 2,  3,  2'b01, 1, 40, 30, 2'b00, 1,   0,   6,    0};
    vecs[7] = '{1, 2,  3,  2'b01, 1, 40, 30, 2'b00, 0,   1,   70,   1};

    rst = 1'b1;
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_func = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_func = 0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    chk("rst_resp_valid", {resp1_valid, resp0_valid}, 0);
    chk("rst_resp_out", resp_out, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_func", alu_func, 0);

    prev_edge = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #2;
      drive(vecs[i]);
      wait_accept(port, edge_n, ok);
      chk("accept_seen", ok, 1);
      chk("grant_port", port, vecs[i].exp_port);
      if (i >= 5) chk("accept_spacing", edge_n - prev_edge, ALU_LAT + 2);
      prev_edge = edge_n;
      ea = (vecs[i].exp_port == 1) ? int'(vecs[i].a1) : int'(vecs[i].a0);
      eb = (vecs[i].exp_port == 1) ? int'(vecs[i].b1) : int'(vecs[i].b0);
      ef = (vecs[i].exp_port == 1) ? int'(vecs[i].f1) : int'(vecs[i].f0);
      @(posedge clk); #2;
      if (!vecs[i].hold) drop_valids();
      wait_resp(edge_n, vecs[i].exp_port, vecs[i].exp_out, vecs[i].exp_err,
                ea, eb, ef, !vecs[i].hold);
    end

    // Reset during EXEC of a port-0 op (rr_ptr is 1 after this accept).
    @(posedge clk); #2;
    req0_valid = 1; req0_a = 9; req0_b = 9; req0_func = 2'b00;
    wait_accept(port, edge_n, ok);
    chk("rst_case_accept", ok, 1);
    chk("rst_case_port", port, 0);
    @(posedge clk); #2;
    drop_valids();
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    r0_cnt = 0; r1_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) begin
        chk("rst_exec_busy", busy, 0);
        chk("rst_exec_alu_a", alu_a, 0);
        chk("rst_exec_resp_out", resp_out, 0);
      end
      if (resp0_valid) r0_cnt++;
      if (resp1_valid) r1_cnt++;
    end
    chk("rst_exec_no_resp0", r0_cnt, 0);
    chk("rst_exec_no_resp1", r1_cnt, 0);

    @(posedge clk); #2;
    req0_valid = 1; req0_a = 1; req0_b = 2; req0_func = 2'b00;
    req1_valid = 1; req1_a = 4; req1_b = 4; req1_func = 2'b00;
    wait_accept(port, edge_n, ok);
    chk("post_rst_accept", ok, 1);
    chk("post_rst_grant", port, 0);
    @(posedge clk); #2;
    drop_valids();
    wait_resp(edge_n, 0, 3, 0, 1, 2, 0, 1);

    // Port 0 raises valid while port 1 is busy and withdraws it before IDLE.
`ifdef ALU_SHARE_STATS_EN
    gc0_before = grant_cnt0;
`endif
    @(posedge clk); #2;
    req1_valid = 1; req1_a = 7; req1_b = 8; req1_func = 2'b01;
    wait_accept(port, edge_n, ok);
    chk("wd_accept", ok, 1);
    chk("wd_port", port, 1);
    @(posedge clk); #2;
    req1_valid = 0;
    req0_valid = 1; req0_a = 3; req0_b = 3; req0_func = 2'b00;
    r0_cnt = 0; r1_cnt = 0; rdy0_cnt = 0; r1_out = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (req0_ready) rdy0_cnt++;
      if (resp0_valid) r0_cnt++;
      if (resp1_valid) begin r1_cnt++; r1_out = resp_out; end
      if (k == 0) begin
        @(posedge clk); #2;
        req0_valid = 0;
      end
    end
    chk("wd_no_ready0", rdy0_cnt, 0);
    chk("wd_no_resp0", r0_cnt, 0);
    chk("wd_resp1_count", r1_cnt, 1);
    chk("wd_resp1_out", r1_out, 56);
`ifdef ALU_SHARE_STATS_EN
    chk("wd_grant_cnt0", grant_cnt0, gc0_before);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
